// File: rtl/mio_bus_ctrl_pkg.sv
// rtl/mio_bus_ctrl_pkg.sv - shared types and constants for the MIO bus controller
package mio_bus_ctrl_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mio_state_t;

  // Read data returned on any errored read
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of a saturating counter able to hold the value t
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// rtl/mio_bus_ctrl_if.sv - CPU data port and slave-side bus of the MIO controller
interface mio_bus_ctrl_if #(
  parameter int N_SLV = 4,
  parameter int AW    = 9
);

  // CPU side
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;
  logic                  cpu_err;

  // Slave side
  logic [N_SLV-1:0]      slv_sel;
  logic                  slv_we;
  logic [AW-1:0]         slv_addr;
  logic [31:0]           slv_wdata;
  logic [N_SLV*32-1:0]   slv_rdata;
  logic [N_SLV-1:0]      slv_ack;

  // The controller: answers the CPU and masters the slave bus
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_err,
    output slv_sel, slv_we, slv_addr, slv_wdata,
    input  slv_rdata, slv_ack
  );

  // The endpoints: the CPU issuing requests and the slaves answering them
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  slv_sel, slv_we, slv_addr, slv_wdata,
    output slv_rdata, slv_ack
  );

endinterface

// File: rtl/mio_addr_decode.sv
// rtl/mio_addr_decode.sv - address nibble to one-hot slave select, lowest index wins
module mio_addr_decode #(
  parameter int                   N_SLV    = 4,
  parameter logic [N_SLV*4-1:0]   SLV_BASE = 16'hfed0
) (
  input  logic [3:0]       nibble,
  output logic [N_SLV-1:0] sel,
  output logic             hit
);

  // Scan from the top so the lowest matching slave is the one left selected
  always_comb begin
    sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (nibble == SLV_BASE[4*i +: 4]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    hit = |sel;
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - handshaked MIO address decoder / bus controller; optional MIO_BUS_TIMEOUT_EN
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int                 N_SLV    = 4,
  parameter int                 AW       = 9,
  parameter logic [N_SLV*4-1:0] SLV_BASE = 16'hfed0,
  parameter int                 TIMEOUT  = 255,
  parameter logic [31:0]        ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mio_bus_ctrl_if.master bus
);

  // Reject configurations the select vector and counter cannot represent
  if (N_SLV < 1 || N_SLV > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mio_bus_ctrl: N_SLV must be 1..8 and TIMEOUT at least 1");
  end

  mio_state_t       state;
  logic [N_SLV-1:0] dec_sel;
  logic             dec_hit;
  logic [31:0]      rdata_mux;
  logic             ack_hit;

  logic             ready_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [N_SLV-1:0] sel_q;
  logic             we_q;
  logic             slv_we_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;

`ifdef MIO_BUS_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT);
  logic [TW-1:0] to_cnt;
`endif

  mio_addr_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE)
  ) u_decode (
    .nibble (bus.cpu_addr[31:28]),
    .sel    (dec_sel),
    .hit    (dec_hit)
  );

  // Pick the selected slave's read slice; only the selected slave's ack counts
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) begin
        rdata_mux = rdata_mux | bus.slv_rdata[32*i +: 32];
      end
    end
    ack_hit = |(bus.slv_ack & sel_q);
  end

  // FSM with request latches, read-data capture and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      slv_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef MIO_BUS_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            if (dec_hit) begin
              state    <= ST_ACCESS;
              sel_q    <= dec_sel;
              we_q     <= bus.cpu_we;
              slv_we_q <= bus.cpu_we;
              addr_q   <= bus.cpu_addr[AW+1:2];
              wdata_q  <= bus.cpu_wdata;
`ifdef MIO_BUS_TIMEOUT_EN
              to_cnt   <= '0;
`endif
            end else begin
              // Unmapped: answer directly without touching any slave
              state   <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= bus.cpu_we ? 32'h0 : ERR_DATA;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_hit) begin
            state    <= ST_RESP;
            ready_q  <= 1'b1;
            sel_q    <= '0;
            slv_we_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= rdata_mux;
            end
          end
`ifdef MIO_BUS_TIMEOUT_EN
          // Ack has priority over an expiring count in the same cycle
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state    <= ST_RESP;
            ready_q  <= 1'b1;
            err_q    <= 1'b1;
            sel_q    <= '0;
            slv_we_q <= 1'b0;
            rdata_q  <= we_q ? 32'h0 : ERR_DATA;
          end else if (to_cnt != TW'(TIMEOUT)) begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = slv_we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - directed self-checking bench for mio_bus_ctrl
module tb_mio_bus_ctrl;

  localparam int N_SLV = 4;
  localparam int AW    = 9;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mio_bus_ctrl_if #(.N_SLV(N_SLV), .AW(AW)) bus ();

  mio_bus_ctrl #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .SLV_BASE (16'hfed0),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.slv_ack   = '0;
    bus.slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
    tick();
    tick();
    check("reset_ready", bus.cpu_ready, 1'b0);
    check("reset_err",   bus.cpu_err,   1'b0);
    check("reset_sel",   bus.slv_sel,   4'b0000);
    check("reset_rdata", bus.cpu_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: read RAM, immediate ack
    bus.slv_ack  = 4'b0001;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0010;
    tick();
    bus.cpu_req = 1'b0;
    check("t1_sel_c1",   bus.slv_sel,   4'b0001);
    check("t1_addr_c1",  bus.slv_addr,  9'd4);
    check("t1_we_c1",    bus.slv_we,    1'b0);
    check("t1_ready_c1", bus.cpu_ready, 1'b0);
    tick();
    check("t1_ready_c2", bus.cpu_ready, 1'b1);
    check("t1_err_c2",   bus.cpu_err,   1'b0);
    check("t1_rdata_c2", bus.cpu_rdata, 32'h1234_5678);
    check("t1_sel_c2",   bus.slv_sel,   4'b0000);
    tick();
    check("t1_ready_c3", bus.cpu_ready, 1'b0);
    check("t1_hold_c3",  bus.cpu_rdata, 32'h1234_5678);

    // 2: write GPIO with three wait states
    bus.slv_ack   = 4'b0000;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'hE000_0000;
    bus.cpu_wdata = 32'h0000_00A5;
    tick();
    bus.cpu_req = 1'b0;
    check("t2_sel_c1",   bus.slv_sel,   4'b0100);
    check("t2_we_c1",    bus.slv_we,    1'b1);
    check("t2_wdata_c1", bus.slv_wdata, 32'h0000_00A5);
    tick();
    tick();
    check("t2_sel_c3",   bus.slv_sel,   4'b0100);
    tick();
    check("t2_sel_c4",   bus.slv_sel,   4'b0100);
    check("t2_ready_c4", bus.cpu_ready, 1'b0);
    bus.slv_ack = 4'b0100;
    tick();
    bus.slv_ack = 4'b0000;
    check("t2_ready_c5", bus.cpu_ready, 1'b1);
    check("t2_err_c5",   bus.cpu_err,   1'b0);
    check("t2_rdata_c5", bus.cpu_rdata, 32'h1234_5678);
    check("t2_sel_c5",   bus.slv_sel,   4'b0000);
    check("t2_we_c5",    bus.slv_we,    1'b0);
    tick();

    // 3: unmapped read
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h5000_0000;
    tick();
    bus.cpu_req = 1'b0;
    check("t3_ready_c1", bus.cpu_ready, 1'b1);
    check("t3_err_c1",   bus.cpu_err,   1'b1);
    check("t3_rdata_c1", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("t3_sel_c1",   bus.slv_sel,   4'b0000);
    tick();
    check("t3_ready_c2", bus.cpu_ready, 1'b0);
    check("t3_err_c2",   bus.cpu_err,   1'b0);

    // 6: spurious ack from slave1 while slave3 selected; req held through RESP
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'hF000_0004;
    tick();
    check("t6_sel_c1", bus.slv_sel, 4'b1000);
    bus.slv_ack = 4'b0010;
    tick();
    check("t6_sel_c2",   bus.slv_sel,   4'b1000);
    check("t6_ready_c2", bus.cpu_ready, 1'b0);
    bus.slv_ack = 4'b1000;
    tick();
    bus.slv_ack = 4'b0000;
    check("t6_ready_c3", bus.cpu_ready, 1'b1);
    check("t6_rdata_c3", bus.cpu_rdata, 32'h3333_3333);
    tick();
    bus.cpu_req = 1'b0;
    check("t6_sel_c4",   bus.slv_sel,   4'b0000);
    check("t6_ready_c4", bus.cpu_ready, 1'b0);
    tick();
    check("t6_sel_c5",   bus.slv_sel,   4'b0000);

    // 4: slave1 never acks
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'hD000_0000;
    tick();
    bus.cpu_req = 1'b0;
    check("t4_sel_c1", bus.slv_sel, 4'b0010);
`ifdef MIO_BUS_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) tick();
    check("t4_sel_c8",   bus.slv_sel,   4'b0010);
    check("t4_ready_c8", bus.cpu_ready, 1'b0);
    tick();
    check("t4_ready_c9", bus.cpu_ready, 1'b1);
    check("t4_err_c9",   bus.cpu_err,   1'b1);
    check("t4_rdata_c9", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("t4_sel_c9",   bus.slv_sel,   4'b0000);
    tick();
    // start a fresh access for the reset test
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'hD000_0000;
    tick();
    bus.cpu_req = 1'b0;
    tick();
`else
    begin
      int seen_ready;
      seen_ready = 0;
      for (int i = 2; i <= 1000; i++) begin
        tick();
        if (bus.cpu_ready === 1'b1) seen_ready++;
      end
      check("t4_no_ready", seen_ready, 0);
    end
    check("t4_ready_c1000", bus.cpu_ready, 1'b0);
`endif
    check("t5_sel_pre", bus.slv_sel, 4'b0010);

    // 5: asynchronous reset mid-ACCESS
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_sel_rst",   bus.slv_sel,   4'b0000);
    check("t5_ready_rst", bus.cpu_ready, 1'b0);
    check("t5_err_rst",   bus.cpu_err,   1'b0);
    check("t5_rdata_rst", bus.cpu_rdata, 32'h0);
    tick();
    bus.slv_ack = 4'b0010;
    tick();
    check("t5_ready_inrst", bus.cpu_ready, 1'b0);
    rst_n = 1'b1;
    bus.slv_ack = 4'b0001;
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0010;
    tick();
    bus.cpu_req = 1'b0;
    check("t5_sel_c1",   bus.slv_sel,   4'b0001);
    tick();
    check("t5_ready_c2", bus.cpu_ready, 1'b1);
    check("t5_err_c2",   bus.cpu_err,   1'b0);
    check("t5_rdata_c2", bus.cpu_rdata, 32'h1234_5678);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
